// File: rtl/reg_flag_wb_pkg.sv
// Shared types and constants for the reg_flag_wb writeback stage.
package reg_flag_wb_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;

    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [AW_DEF-1:0] adr;
        logic              ena;
    } signal_alu_wr_reg;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic ena;
        logic rav_adr;
        logic ena_ra;
    } signal_flag_wr_alu;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic rav_adr;
    } signal_flag_alu;

    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/reg_flag_wb_flags.sv
// Architectural flag register: clear/load priority and sticky non-one-hot error.
module reg_flag_wb_flags
    import reg_flag_wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  signal_flag_wr_alu flag_wr,
    input  logic              flag_clr,
    output signal_flag_alu    flags,
    output logic              flag_err
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags    <= '0;
            flag_err <= 1'b0;
        end else if (flag_clr) begin
            flags <= '0;
        end else begin
            if (flag_wr.ena) begin
                flags.bolshe <= flag_wr.bolshe;
                flags.menshe <= flag_wr.menshe;
                flags.ravno  <= flag_wr.ravno;
                if (!is_one_hot3({flag_wr.bolshe, flag_wr.menshe, flag_wr.ravno}))
                    flag_err <= 1'b1;
            end
            // rav_adr loads independently, so both enables may act in one cycle
            if (flag_wr.ena_ra)
                flags.rav_adr <= flag_wr.rav_adr;
        end
    end

endmodule

// File: rtl/reg_flag_wb.sv
// Writeback stage: register file with one pending-write buffer and bypass, plus flags.
// Optional macro FWD_EN adds same-cycle bypass from the ALU write inputs to the read ports.
module reg_flag_wb
    import reg_flag_wb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_ena_i,
    input  logic [AW-1:0]    wr_adr_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             flag_ena_i,
    input  logic             bolshe_i,
    input  logic             menshe_i,
    input  logic             ravno_i,
    input  logic             ena_ra_i,
    input  logic             rav_adr_i,
    input  logic             flag_clr_i,
    input  logic [AW-1:0]    rd_adr_a_i,
    input  logic [AW-1:0]    rd_adr_b_i,
    output logic [DW-1:0]    rd_data_a_o,
    output logic [DW-1:0]    rd_data_b_o,
    output logic             bolshe_o,
    output logic             menshe_o,
    output logic             ravno_o,
    output logic             rav_adr_o,
    output logic             flag_err_o,
    output logic [CNT_W-1:0] wr_cnt_o
);

    localparam int DEPTH = 2 ** AW;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [DW-1:0]    mem [DEPTH];
    logic             pend_vld;
    logic [AW-1:0]    pend_adr;
    logic [DW-1:0]    pend_data;
    logic [CNT_W-1:0] wr_cnt;

    // NOTE: the file is cleared by reset because every entry must read 0 afterwards; this forbids RAM macro mapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend_vld  <= 1'b0;
            pend_adr  <= '0;
            pend_data <= '0;
            wr_cnt    <= '0;
        end else begin
            pend_vld <= wr_ena_i;
            if (wr_ena_i) begin
                pend_adr  <= wr_adr_i;
                pend_data <= wr_data_i;
            end
            if (pend_vld) begin
                mem[pend_adr] <= pend_data;
                wr_cnt        <= wr_cnt + 1'b1;
            end
        end
    end

    // NOTE: each output gets a default before the overrides, so no latch is inferred.
    always_comb begin
        rd_data_a_o = mem[rd_adr_a_i];
        rd_data_b_o = mem[rd_adr_b_i];
        if (pend_vld && pend_adr == rd_adr_a_i) rd_data_a_o = pend_data;
        if (pend_vld && pend_adr == rd_adr_b_i) rd_data_b_o = pend_data;
        if (FWD && wr_ena_i && wr_adr_i == rd_adr_a_i) rd_data_a_o = wr_data_i;
        if (FWD && wr_ena_i && wr_adr_i == rd_adr_b_i) rd_data_b_o = wr_data_i;
    end

    signal_flag_wr_alu flag_wr;
    signal_flag_alu    flags;

    assign flag_wr = '{bolshe: bolshe_i, menshe: menshe_i, ravno: ravno_i,
                       ena: flag_ena_i, rav_adr: rav_adr_i, ena_ra: ena_ra_i};

    reg_flag_wb_flags u_flags (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flag_wr  (flag_wr),
        .flag_clr (flag_clr_i),
        .flags    (flags),
        .flag_err (flag_err_o)
    );

    assign bolshe_o  = flags.bolshe;
    assign menshe_o  = flags.menshe;
    assign ravno_o   = flags.ravno;
    assign rav_adr_o = flags.rav_adr;
    assign wr_cnt_o  = wr_cnt;

endmodule

// File: tb/tb_reg_flag_wb.sv
// Directed table-driven bench for reg_flag_wb plus reset, bypass and counter-wrap sequences.
module tb_reg_flag_wb;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wr_ena_i, flag_ena_i, bolshe_i, menshe_i, ravno_i;
    logic             ena_ra_i, rav_adr_i, flag_clr_i;
    logic [AW-1:0]    wr_adr_i, rd_adr_a_i, rd_adr_b_i;
    logic [DW-1:0]    wr_data_i, rd_data_a_o, rd_data_b_o;
    logic             bolshe_o, menshe_o, ravno_o, rav_adr_o, flag_err_o;
    logic [CNT_W-1:0] wr_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    reg_flag_wb #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_ena_i    (wr_ena_i),
        .wr_adr_i    (wr_adr_i),
        .wr_data_i   (wr_data_i),
        .flag_ena_i  (flag_ena_i),
        .bolshe_i    (bolshe_i),
        .menshe_i    (menshe_i),
        .ravno_i     (ravno_i),
        .ena_ra_i    (ena_ra_i),
        .rav_adr_i   (rav_adr_i),
        .flag_clr_i  (flag_clr_i),
        .rd_adr_a_i  (rd_adr_a_i),
        .rd_adr_b_i  (rd_adr_b_i),
        .rd_data_a_o (rd_data_a_o),
        .rd_data_b_o (rd_data_b_o),
        .bolshe_o    (bolshe_o),
        .menshe_o    (menshe_o),
        .ravno_o     (ravno_o),
        .rav_adr_o   (rav_adr_o),
        .flag_err_o  (flag_err_o),
        .wr_cnt_o    (wr_cnt_o)
    );

    typedef struct {
        logic             we;
        logic [AW-1:0]    wa;
        logic [DW-1:0]    wd;
        logic             fe;
        logic [2:0]       bmr;
        logic             era;
        logic             rav;
        logic             clr;
        logic [AW-1:0]    ra;
        logic [AW-1:0]    rb;
        logic [DW-1:0]    ea;
        logic [DW-1:0]    eb;
        logic [3:0]       ef;   // {bolshe, menshe, ravno, rav_adr}
        logic             ee;
        logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic fe, input logic [2:0] bmr, input logic era, input logic rav,
        input logic clr, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
        input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [3:0] ef,
        input logic ee, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.fe = fe; v.bmr = bmr; v.era = era;
        v.rav = rav; v.clr = clr; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        v.ef = ef; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_ena_i   = 1'b0;
        flag_ena_i = 1'b0;
        ena_ra_i   = 1'b0;
        flag_clr_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           we wa  wd       fe bmr    era rav clr ra  rb  ea       eb       ef       ee  ec
        vecs[0]  = mk(1, 3, 16'h1234, 0, 3'b000, 0, 0, 0, 3,  3,  16'h1234, 16'h1234, 4'b0000, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 3'b000, 0, 0, 0, 3,  0,  16'h1234, 16'h0000, 4'b0000, 0, 1);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 3'b000, 0, 0, 0, 3,  3,  16'h1234, 16'h1234, 4'b0000, 0, 1);
        vecs[3]  = mk(1, 5, 16'h0001, 0, 3'b000, 0, 0, 0, 5,  3,  16'h0001, 16'h1234, 4'b0000, 0, 1);
        vecs[4]  = mk(1, 5, 16'h0002, 0, 3'b000, 0, 0, 0, 5,  5,  16'h0002, 16'h0002, 4'b0000, 0, 2);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 3'b000, 0, 0, 0, 5,  5,  16'h0002, 16'h0002, 4'b0000, 0, 3);
        vecs[6]  = mk(0, 0, 16'h0000, 1, 3'b100, 0, 0, 0, 5,  3,  16'h0002, 16'h1234, 4'b1000, 0, 3);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 3'b000, 1, 1, 0, 5,  3,  16'h0002, 16'h1234, 4'b1001, 0, 3);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 3'b001, 0, 0, 1, 5,  3,  16'h0002, 16'h1234, 4'b0000, 0, 3);
        vecs[9]  = mk(0, 0, 16'h0000, 1, 3'b110, 0, 0, 1, 5,  3,  16'h0002, 16'h1234, 4'b0000, 0, 3);
        vecs[10] = mk(0, 0, 16'h0000, 1, 3'b010, 1, 1, 0, 5,  3,  16'h0002, 16'h1234, 4'b0101, 0, 3);
        vecs[11] = mk(0, 0, 16'h0000, 1, 3'b110, 0, 0, 0, 5,  3,  16'h0002, 16'h1234, 4'b1101, 1, 3);
        vecs[12] = mk(0, 0, 16'h0000, 1, 3'b001, 0, 0, 0, 5,  3,  16'h0002, 16'h1234, 4'b0011, 1, 3);
        vecs[13] = mk(0, 0, 16'h0000, 1, 3'b000, 0, 0, 0, 5,  3,  16'h0002, 16'h1234, 4'b0001, 1, 3);
        vecs[14] = mk(1, 15, 16'hFFFF, 0, 3'b000, 0, 0, 0, 15, 3,  16'hFFFF, 16'h1234, 4'b0001, 1, 3);
        vecs[15] = mk(1, 0, 16'hA5A5, 0, 3'b000, 0, 0, 0, 15, 0,  16'hFFFF, 16'hA5A5, 4'b0001, 1, 4);
        vecs[16] = mk(0, 0, 16'h0000, 0, 3'b000, 0, 0, 0, 0,  15, 16'hA5A5, 16'hFFFF, 4'b0001, 1, 5);

        rst_i = 1'b1;
        idle_inputs();
        wr_adr_i = '0; wr_data_i = '0;
        bolshe_i = 0; menshe_i = 0; ravno_i = 0; rav_adr_i = 0;
        rd_adr_a_i = 3; rd_adr_b_i = 5;
        repeat (2) @(negedge clk_i);
        check("reset rd_a", rd_data_a_o, 0);
        check("reset flags", {bolshe_o, menshe_o, ravno_o, rav_adr_o}, 0);
        check("reset err", flag_err_o, 0);
        check("reset cnt", wr_cnt_o, 0);
        rst_i = 1'b0;

        // Table: apply inputs for one edge, then idle them before sampling the post-edge state
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            wr_ena_i = vecs[i].we; wr_adr_i = vecs[i].wa; wr_data_i = vecs[i].wd;
            flag_ena_i = vecs[i].fe; {bolshe_i, menshe_i, ravno_i} = vecs[i].bmr;
            ena_ra_i = vecs[i].era; rav_adr_i = vecs[i].rav; flag_clr_i = vecs[i].clr;
            rd_adr_a_i = vecs[i].ra; rd_adr_b_i = vecs[i].rb;
            @(posedge clk_i);
            #1 idle_inputs();
            #1;
            check($sformatf("v%0d rd_a", i), rd_data_a_o, vecs[i].ea);
            check($sformatf("v%0d rd_b", i), rd_data_b_o, vecs[i].eb);
            check($sformatf("v%0d flags", i), {bolshe_o, menshe_o, ravno_o, rav_adr_o}, vecs[i].ef);
            check($sformatf("v%0d err", i), flag_err_o, vecs[i].ee);
            check($sformatf("v%0d cnt", i), wr_cnt_o, vecs[i].ec);
        end

        // Asynchronous reset mid-cycle while a write is pending
        @(negedge clk_i);
        wr_ena_i = 1; wr_adr_i = 7; wr_data_i = 16'h7777;
        rd_adr_a_i = 7; rd_adr_b_i = 3;
        @(posedge clk_i);
        #1 idle_inputs();
        #1 check("pend before reset", rd_data_a_o, 16'h7777);
        #2 rst_i = 1'b1;
        #1;
        check("async rst rd_a", rd_data_a_o, 0);
        check("async rst rd_b", rd_data_b_o, 0);
        check("async rst flags", {bolshe_o, menshe_o, ravno_o, rav_adr_o}, 0);
        check("async rst err", flag_err_o, 0);
        check("async rst cnt", wr_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #2;
        check("pend discarded rd_a", rd_data_a_o, 0);
        check("pend discarded cnt", wr_cnt_o, 0);

        // Same-cycle presentation: bypassed only with FWD_EN
        @(negedge clk_i);
        wr_ena_i = 1; wr_adr_i = 7; wr_data_i = 16'hBEEF; rd_adr_a_i = 7;
        #1;
`ifdef FWD_EN
        check("same-cycle fwd", rd_data_a_o, 16'hBEEF);
`else
        check("same-cycle no fwd", rd_data_a_o, 16'h0000);
`endif
        @(posedge clk_i);
        #1 idle_inputs();
        #1 check("bypass after 1 edge", rd_data_a_o, 16'hBEEF);

        // Fifteen more writes, then wrap the 4-bit commit counter
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            wr_ena_i = 1; wr_adr_i = AW'(i); wr_data_i = DW'(16'h0100 + i);
            @(posedge clk_i);
        end
        #1 idle_inputs();
        rd_adr_a_i = 14; rd_adr_b_i = 13;
        #1;
        check("cnt all ones", wr_cnt_o, 4'hF);
        check("r14 pending", rd_data_a_o, 16'h010E);
        @(posedge clk_i);
        #2;
        check("cnt wrap", wr_cnt_o, 4'h0);
        check("r14 committed", rd_data_a_o, 16'h010E);
        check("r13 committed", rd_data_b_o, 16'h010D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_flag_wb.md
Name: reg_flag_wb

Overview:
Writeback stage directly downstream of the ALU. It consumes the ALU's register-write bundle (data/adr/ena) and flag-write bundle (bolshe/menshe/ravno/ena, rav_adr/ena_ra). It owns the general register file, with one pending-write buffer and bypass, and the architectural flag register. Read ports feed operand fetch, and flag outputs feed the ALU flag input used by JN/JR.

Parameters:
DW, 16, register data width
AW, 4, register address width; file depth is 2**AW
CNT_W, 16, width of committed-write counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
wr_ena_i  in  1  ALU register-write enable
wr_adr_i  in  AW  ALU destination register
wr_data_i  in  DW  ALU result
flag_ena_i  in  1  load compare flags
bolshe_i  in  1  a>b
menshe_i  in  1  a<b
ravno_i  in  1  a==b
ena_ra_i  in  1  load rav_adr flag
rav_adr_i  in  1  address-match flag
flag_clr_i  in  1  synchronous clear of all flags
rd_adr_a_i  in  AW  read port A address
rd_adr_b_i  in  AW  read port B address
rd_data_a_o  out  DW  read port A data (combinational)
rd_data_b_o  out  DW  read port B data (combinational)
bolshe_o, menshe_o, ravno_o, rav_adr_o  out  1 each  architectural flags
flag_err_o  out  1  sticky: flag load was not one-hot
wr_cnt_o  out  CNT_W  count of committed register writes

Behaviour:
- Reset (async, rst_i=1): every file entry = 0. Pending buffer is invalid (pend_vld=0, pend_adr=0, pend_data=0). All flags, flag_err_o, and wr_cnt_o = 0. Reset mid-operation discards any pending write.
- Two-step write. At edge E, if wr_ena_i=1, {wr_adr_i, wr_data_i} is captured into the pending buffer and pend_vld=1; otherwise pend_vld=0. At the same edge, if pend_vld was 1, the previous pending entry commits to the file and wr_cnt_o increments.
- Latency: input write to array is 2 edges. Input write to reads is 1 edge, via bypass.
- Back-to-back writes to the same address: the older one commits and the newer one becomes pending. Reads see the newer one.
- Read mux, per port, highest priority first:
  - Same-cycle input when FWD_EN is defined, wr_ena_i=1 and address matches.
  - Pending buffer when pend_vld=1 and address matches.
  - File entry.
- Ports A and B are independent and may use the same address.
- Flags, evaluated at each edge in this order:
  - flag_clr_i=1: all four flags <= 0. Clear wins over simultaneous loads.
  - Otherwise, flag_ena_i=1: {bolshe,menshe,ravno} <= inputs.
  - Otherwise, ena_ra_i=1: rav_adr <= rav_adr_i. This is independent of flag_ena_i, so both may load in one cycle.
  - Flags with their enable low hold their value.
- flag_err_o: set at an edge where flag_ena_i=1, flag_clr_i=0 and {bolshe_i,menshe_i,ravno_i} is not one-hot. It stays set until reset. The flag load still occurs.
- wr_cnt_o wraps from 2**CNT_W-1 to 0.
- Flag outputs are registered. Read outputs are combinational from addresses.

Optional Feature:
FWD_EN
- Defined: a same-cycle input write (wr_ena_i, wr_adr_i) bypasses to read ports, so the value is visible 0 edges after presentation. This adds a combinational path from wr_data_i to rd_data_*.
- Undefined: no input bypass. Reads see a write 1 edge after it is presented, and operand fetch must stall 1 cycle on a same-address dependency.

Decomposition:
- Shared package holds:
  - signal_alu_wr_reg {data, adr, ena}
  - signal_flag_wr_alu {bolshe, menshe, ravno, ena, rav_adr, ena_ra}
  - signal_flag_alu
  - DW/AW constants
- Natural sub-module: reg_flag_wb_flags, containing the flag register, clear/load priority and the sticky error. File, pending buffer and bypass stay in the top.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with pend_vld=1 -> all reads 0, flags 0, wr_cnt_o=0. The pending write never lands.
- Write r3=0x1234, then idle. Reading r3 returns 0x1234 after edge 1 from the pending buffer, and after edge 2 from the array. wr_cnt_o=1 after edge 2.
- Back-to-back writes r5=0x0001 then r5=0x0002 -> r5 reads 0x0002 after edge 2 and stays 0x0002 after both commit. wr_cnt_o=2.
- FWD_EN defined: drive wr_ena_i=1, adr=7, data=0xBEEF with rd_adr_a_i=7 -> rd_data_a_o=0xBEEF in the same cycle. With FWD_EN undefined, the old value is returned in that cycle.
- Flags: flag_ena_i=1 with {1,0,0}, then ena_ra_i=1 with rav_adr_i=1, then flag_clr_i=1 together with flag_ena_i=1 {0,0,1} -> outputs {1,0,0,0}, then {1,0,0,1}, then {0,0,0,0}.
- Error: flag_ena_i=1 with {1,1,0} -> flag_err_o=1 after the edge and stays 1 through later valid loads until rst_i.
